fwrisc_alu_mc: RTL and testbench
================================

Name: fwrisc_alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's single-cycle ALU.
- Adds full shift amounts (iterative shifter, SHIFT_STEP bits per cycle), set-less-than ops, and real carry/borrow and zero flags.
- Uses valid/ready handshakes on input and output, so the core's execute stage stalls on variable-latency shifts instead of looping single-bit shifts itself.

Parameters:
- WIDTH, 32, datapath width in bits; power of 2, minimum 8.
- SHIFT_STEP, 1, maximum bit positions shifted per cycle; power of 2, 1..WIDTH.
- SAW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10-15 behave as ADD.
- op_a  in  WIDTH  operand A / shift source.
- op_b  in  WIDTH  operand B; shift amount is op_b[SAW-1:0], upper bits ignored.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  registered result.
- carry  out  1  ADD: carry-out bit WIDTH; SUB: borrow (op_a < op_b unsigned); 0 for all other ops.
- eqz  out  1  out == 0, for every op.

Behaviour:
- Reset: state=IDLE; out=0, carry=0, eqz=0, out_valid=0, in_ready=1 in the cycle after reset. Internal shift counter and accumulator cleared.
- Reset mid-operation (SHIFT or DONE): the operation is discarded with no out_valid pulse; block returns to IDLE next cycle.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, in_valid=1: operands are captured on that edge (handshake fires).
  - Non-shift op: result computed combinationally, registered into out/carry/eqz → DONE.
  - Shift op: accumulator=op_a, cnt=shamt, opcode latched. shamt==0 → out=op_a, → DONE. Otherwise → SHIFT.
- SHIFT: each cycle, step s=min(SHIFT_STEP, cnt).
  - Accumulator shifted by s: SLL zero-fill; SRL zero-fill; SRA fills with the original op_a MSB.
  - cnt -= s. When cnt becomes 0, out is loaded from the accumulator and state → DONE.
- DONE: out_valid=1; out/carry/eqz held stable. out_ready=1 → IDLE (out_valid drops the next cycle). in_ready stays 0 in SHIFT and DONE. There is no back-to-back acceptance in the same cycle as output accept.
- Latency (accept edge = cycle 0):
  - Non-shift ops, or shift with shamt==0: out_valid in cycle 1.
  - Shift: out_valid in cycle 1 + ceil(shamt/SHIFT_STEP).
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit sum; out = low WIDTH bits, wrapping.
  - SLT: signed compare, out = {0…, a<b}.
  - SLTU: unsigned compare, out = {0…, a<b}.
- Stall: out_valid stays high with out unchanged for arbitrary out_ready=0 durations.
- in_valid while busy is ignored; the producer must hold in_valid until it sees in_ready.

Test Plan (WIDTH=32 unless noted):
- ADD op_a=0xFFFFFFFF, op_b=1, out_ready=1 → out_valid in cycle 1; out=0, carry=1, eqz=1; in_ready high again in cycle 2.
- SUB op_a=3, op_b=5 → out=0xFFFFFFFE, carry=1, eqz=0. SLT with the same operands → out=1. SLTU op_a=0xFFFFFFFF, op_b=1 → out=0.
- SRA op_a=0x80000000, op_b=0x0000001F, SHIFT_STEP=1 → out_valid in cycle 32, out=0xFFFFFFFF. Rerun with SHIFT_STEP=4 → cycle 9, same value.
- SLL op_a=0x1, op_b=0xFFFFFF00 (shamt=0) → out_valid in cycle 1, out=0x1. SRL op_a=0x80000000, shamt=31 → out=0x1.
- Back-pressure: XOR 0xA5A5A5A5 ^ 0x5A5A5A5A with out_ready=0 for 5 cycles → out=0xFFFFFFFF held and in_ready=0 throughout; out_ready=1 → IDLE next cycle.
- Reset asserted mid-SHIFT (SLL, shamt=20, cycle 5) → no out_valid pulse; out=0, in_ready=1 in the cycle after reset.
- Cover WIDTH=8 ADD 0x80+0x80 → out=0x00, carry=1, eqz=1.

Source files
------------

// File: rtl/fwrisc_alu_mc.sv
// rtl/fwrisc_alu_mc.sv - multi-cycle ALU with iterative shifter, flags and valid/ready handshakes
module fwrisc_alu_mc #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1,
    parameter int SAW        = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             eqz
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    // One extra bit so SHIFT_STEP == WIDTH is representable.
    localparam logic [SAW:0] STEP_W = (SAW+1)'(SHIFT_STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SAW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             eqz_q, eqz_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             is_shift;
    logic [SAW-1:0]   shamt;
    logic [SAW-1:0]   step_s;
    logic [SAW-1:0]   cnt_next;
    logic [WIDTH-1:0] acc_shifted;

    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        diff      = {1'b0, op_a} - {1'b0, op_b};
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        case (op)
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            OP_AND: begin
                alu_res   = op_a & op_b;
                alu_carry = 1'b0;
            end
            OP_OR: begin
                alu_res   = op_a | op_b;
                alu_carry = 1'b0;
            end
            OP_XOR: begin
                alu_res   = op_a ^ op_b;
                alu_carry = 1'b0;
            end
            OP_SLT: begin
                alu_res   = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                alu_carry = 1'b0;
            end
            OP_SLTU: begin
                alu_res   = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
                alu_carry = 1'b0;
            end
            default: ;
        endcase
        is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
        shamt    = op_b[SAW-1:0];
    end

    // The accumulator MSB stays the original op_a MSB under SRA, so >>> gives the right fill.
    always_comb begin
        step_s   = ({1'b0, cnt_q} > STEP_W) ? STEP_W[SAW-1:0] : cnt_q;
        cnt_next = cnt_q - step_s;
        case (op_q)
            OP_SLL:  acc_shifted = acc_q << step_s;
            OP_SRL:  acc_shifted = acc_q >> step_s;
            default: acc_shifted = $unsigned($signed(acc_q) >>> step_s);
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        eqz_d   = eqz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (is_shift) begin
                        acc_d   = op_a;
                        cnt_d   = shamt;
                        carry_d = 1'b0;
                        if (shamt == '0) begin
                            out_d   = op_a;
                            eqz_d   = (op_a == '0);
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        out_d   = alu_res;
                        carry_d = alu_carry;
                        eqz_d   = (alu_res == '0);
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_next;
                if (cnt_next == '0) begin
                    out_d   = acc_shifted;
                    eqz_d   = (acc_shifted == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            eqz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            eqz_q   <= eqz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign carry     = carry_q;
    assign eqz       = eqz_q;

endmodule

// File: tb/tb_fwrisc_alu_mc.sv
// tb/tb_fwrisc_alu_mc.sv - directed-vector bench for fwrisc_alu_mc (32-bit step 1 and 4, 8-bit step 1)
module tb_fwrisc_alu_mc;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        in_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] op_a, op_b;

    logic        in_ready, out_valid, carry, eqz;
    logic [31:0] out;
    logic        in_ready4, out_valid4, carry4, eqz4;
    logic [31:0] out4;

    logic        in_valid8, out_ready8, in_ready8, out_valid8, carry8, eqz8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, out8;

    int total = 0;
    int bad   = 0;

    int          lat1, lat4, lat8;
    logic [31:0] r_out, r_out4;
    logic        r_carry, r_eqz, r_carry4, r_eqz4;
    logic [7:0]  r_out8;
    logic        r_carry8, r_eqz8;
    int          seen;

    fwrisc_alu_mc #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .eqz(eqz)
    );

    fwrisc_alu_mc #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out(out4), .carry(carry4), .eqz(eqz4)
    );

    fwrisc_alu_mc #(.WIDTH(8), .SHIFT_STEP(1)) u_dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .op_a(a8), .op_b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .carry(carry8), .eqz(eqz8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        check("in_ready_pre", {31'b0, in_ready}, 32'd1);
        check("in_ready4_pre", {31'b0, in_ready4}, 32'd1);
        op = o; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat1 = 0; lat4 = 0; r_out = '0; r_out4 = '0;
        r_carry = 1'b0; r_eqz = 1'b0; r_carry4 = 1'b0; r_eqz4 = 1'b0;
        for (int c = 1; c <= 80 && (lat1 == 0 || lat4 == 0); c++) begin
            if (lat1 == 0 && out_valid) begin
                lat1 = c; r_out = out; r_carry = carry; r_eqz = eqz;
            end
            if (lat4 == 0 && out_valid4) begin
                lat4 = c; r_out4 = out4; r_carry4 = carry4; r_eqz4 = eqz4;
            end
            @(posedge clock); #1;
        end
        check("in_ready_post", {31'b0, in_ready}, 32'd1);
        check("out_valid_post", {31'b0, out_valid}, 32'd0);
        check("in_ready4_post", {31'b0, in_ready4}, 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [31:0] e_out, input logic e_c,
                              input logic e_z, input int e_l1, input int e_l4);
        check({tag, "_out"}, r_out, e_out);
        check({tag, "_carry"}, {31'b0, r_carry}, {31'b0, e_c});
        check({tag, "_eqz"}, {31'b0, r_eqz}, {31'b0, e_z});
        check({tag, "_lat"}, lat1, e_l1);
        check({tag, "_out4"}, r_out4, e_out);
        check({tag, "_carry4"}, {31'b0, r_carry4}, {31'b0, e_c});
        check({tag, "_eqz4"}, {31'b0, r_eqz4}, {31'b0, e_z});
        check({tag, "_lat4"}, lat4, e_l4);
    endtask

    task automatic run_op8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        check("in_ready8_pre", {31'b0, in_ready8}, 32'd1);
        op8 = o; a8 = a; b8 = b; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clock); #1;
        in_valid8 = 1'b0;
        lat8 = 0; r_out8 = '0; r_carry8 = 1'b0; r_eqz8 = 1'b0;
        for (int c = 1; c <= 40 && lat8 == 0; c++) begin
            if (out_valid8) begin
                lat8 = c; r_out8 = out8; r_carry8 = carry8; r_eqz8 = eqz8;
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; op_a = '0; op_b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_out", out, 32'd0);
        check("rst_carry", {31'b0, carry}, 32'd0);
        check("rst_eqz", {31'b0, eqz}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_in_ready4", {31'b0, in_ready4}, 32'd1);
        check("rst_out8", {24'b0, out8}, 32'd0);
        check("rst_in_ready8", {31'b0, in_ready8}, 32'd1);
        @(negedge clock);
        reset = 1'b0;

        run_op(4'd0, 32'hFFFF_FFFF, 32'h1);
        expect_res("add_wrap", 32'h0, 1'b1, 1'b1, 1, 1);
        run_op(4'd1, 32'h3, 32'h5);
        expect_res("sub_borrow", 32'hFFFF_FFFE, 1'b1, 1'b0, 1, 1);
        run_op(4'd1, 32'h7, 32'h7);
        expect_res("sub_zero", 32'h0, 1'b0, 1'b1, 1, 1);
        run_op(4'd8, 32'h3, 32'h5);
        expect_res("slt", 32'h1, 1'b0, 1'b0, 1, 1);
        run_op(4'd8, 32'hFFFF_FFFF, 32'h1);
        expect_res("slt_neg", 32'h1, 1'b0, 1'b0, 1, 1);
        run_op(4'd9, 32'hFFFF_FFFF, 32'h1);
        expect_res("sltu", 32'h0, 1'b0, 1'b1, 1, 1);
        run_op(4'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        expect_res("and", 32'h00F0_F000, 1'b0, 1'b0, 1, 1);
        run_op(4'd3, 32'h0000_1200, 32'h0000_0034);
        expect_res("or", 32'h0000_1234, 1'b0, 1'b0, 1, 1);
        run_op(4'd12, 32'h2, 32'h3);
        expect_res("op12_add", 32'h5, 1'b0, 1'b0, 1, 1);
        run_op(4'd7, 32'h8000_0000, 32'h0000_001F);
        expect_res("sra31", 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 9);
        run_op(4'd5, 32'h1, 32'hFFFF_FF00);
        expect_res("sll0", 32'h1, 1'b0, 1'b0, 1, 1);
        run_op(4'd6, 32'h8000_0000, 32'h0000_001F);
        expect_res("srl31", 32'h1, 1'b0, 1'b0, 32, 9);
        run_op(4'd5, 32'h1, 32'h5);
        expect_res("sll5", 32'h20, 1'b0, 1'b0, 6, 3);

        // back-pressure: result must hold while out_ready is low
        @(negedge clock);
        op = 4'd4; op_a = 32'hA5A5_A5A5; op_b = 32'h5A5A_5A5A; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_out", out, 32'hFFFF_FFFF);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_out4", out4, 32'hFFFF_FFFF);
            @(posedge clock); #1;
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);

        // reset during SHIFT discards the operation
        @(negedge clock);
        op = 4'd5; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 1; c <= 5; c++) begin
            if (out_valid || out_valid4) seen++;
            if (c < 5) begin
                @(posedge clock); #1;
            end
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_in_ready4", {31'b0, in_ready4}, 32'd1);
        check("mid_rst_out", out, 32'd0);
        check("mid_rst_out4", out4, 32'd0);
        check("mid_rst_carry", {31'b0, carry}, 32'd0);
        check("mid_rst_eqz", {31'b0, eqz}, 32'd0);
        for (int c = 0; c < 30; c++) begin
            if (out_valid || out_valid4) seen++;
            @(posedge clock); #1;
        end
        check("mid_rst_no_valid", seen, 32'd0);

        run_op8(4'd0, 8'h80, 8'h80);
        check("w8_add_out", {24'b0, r_out8}, 32'h0);
        check("w8_add_carry", {31'b0, r_carry8}, 32'd1);
        check("w8_add_eqz", {31'b0, r_eqz8}, 32'd1);
        check("w8_add_lat", lat8, 32'd1);
        run_op8(4'd7, 8'h90, 8'h03);
        check("w8_sra_out", {24'b0, r_out8}, 32'hF2);
        check("w8_sra_lat", lat8, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
